chunked_adder: RTL and testbench

//   Parametrised multi-cycle add/subtract unit. It is the sequential successor to the 1-bit full adder.

---
 rtl/chunked_adder_if.sv | 27 ++
 rtl/chunked_adder.sv | 95 +++++++++
 tb/tb_chunked_adder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for the chunked add/subtract unit.
// The master drives operands and out_ready; the slave returns the result.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle, LSB first,
// carry held in a register between slices, valid/ready on both sides.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst,
  chunked_adder_if.slave io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_n;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_n;
  logic [31:0]      base;
  logic [CHUNK:0]   add_s;
  logic             last;

  assign base  = 32'(k) * CHUNK;
  assign last  = (k == KW'(NCHUNK - 1));
  assign add_s = {1'b0, opa[base +: CHUNK]}
               + {1'b0, opb[base +: CHUNK]}
               + {{CHUNK{1'b0}}, carry};

  always_comb begin
    work_n = work;
    work_n[base +: CHUNK] = add_s[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (io.in_valid)  state_n = RUN;
      RUN:     if (last)         state_n = DONE;
      DONE:    if (io.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      carry   <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      work    <= '0;
      io.sum  <= '0;
      io.cout <= 1'b0;
      io.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          opa   <= io.a;
          opb   <= io.sub ? ~io.b : io.b;
          // subtract as a + ~b + !cin
          carry <= io.cin ^ io.sub;
          k     <= '0;
        end
        RUN: begin
          carry <= add_s[CHUNK];
          work  <= work_n;
          k     <= k + 1'b1;
          if (last) begin
            io.sum  <= work_n;
            io.cout <= add_s[CHUNK];
            io.ovf  <= (opa[WIDTH-1] == opb[WIDTH-1])
                    && (work_n[WIDTH-1] != opa[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench: 32/8 vector table plus handshake/reset sequences,
// and an exhaustive sweep of a 3-bit, 1-bit-chunk instance.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(32)) io32 ();
  chunked_adder_if #(.WIDTH(3))  io3 ();

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .io  (io32.slave)
  );

  chunked_adder #(.WIDTH(3), .CHUNK(1)) dut3 (
    .clk (clk),
    .rst (rst),
    .io  (io3.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    @(negedge clk);
    chk("in_ready32", io32.in_ready, 1);
    io32.a = a; io32.b = b; io32.cin = cin; io32.sub = sub;
    io32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io32.in_valid = 1'b0;
    io32.a = $urandom; io32.b = $urandom;
    io32.cin = 1'($urandom); io32.sub = 1'($urandom);
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (io32.out_valid) break;
    end
    if (!io32.out_valid) chk("timeout32", 0, 1);
  endtask

  task automatic drain32();
    @(negedge clk);
    io32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io32.out_ready = 1'b0;
    chk("drain_ov32", io32.out_valid, 0);
  endtask

  task automatic op3(input int a, input int b, input int cin, input int sub);
    int lat;
    int s;
    logic [2:0] bb;
    logic [2:0] es;
    bb = sub ? ~3'(b) : 3'(b);
    s  = a + int'(bb) + (sub ? 1 - cin : cin);
    es = 3'(s);
    @(negedge clk);
    io3.a = 3'(a); io3.b = 3'(b); io3.cin = 1'(cin); io3.sub = 1'(sub);
    io3.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io3.in_valid = 1'b0;
    io3.a = 3'($urandom); io3.b = 3'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (io3.out_valid) break;
    end
    chk("lat3", 64'(lat), 3);
    chk("sum3", io3.sum, 64'(es));
    chk("cout3", io3.cout, 64'(s >> 3 & 1));
    chk("ovf3", io3.ovf, 64'((3'(a) >> 2) == (bb >> 2) && es[2] != 1'(a >> 2)));
    @(negedge clk);
    io3.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io3.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vt[0] = '{32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0};
    vt[1] = '{32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0};
    vt[2] = '{32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1};
    vt[3] = '{32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 0, 0};
    vt[4] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1};
    vt[5] = '{32'h12345678, 32'h87654321, 0, 0, 32'h99999999, 0, 0};
    vt[6] = '{32'h00000005, 32'h00000003, 0, 1, 32'h00000002, 1, 0};
    vt[7] = '{32'h00000005, 32'h00000003, 1, 1, 32'h00000001, 1, 0};
    vt[8] = '{32'h00FF00FF, 32'h00010001, 1, 0, 32'h01000101, 0, 0};
    vt[9] = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1};

    io32.in_valid = 0; io32.out_ready = 0;
    io32.a = 0; io32.b = 0; io32.cin = 0; io32.sub = 0;
    io3.in_valid = 0; io3.out_ready = 0;
    io3.a = 0; io3.b = 0; io3.cin = 0; io3.sub = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", io32.in_ready, 1);
    chk("rst_out_valid", io32.out_valid, 0);
    chk("rst_sum", io32.sum, 0);
    chk("rst_cout_ovf", {io32.cout, io32.ovf}, 0);
    chk("rst_out_valid3", io3.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      start32(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
      wait32(lat);
      chk($sformatf("lat[%0d]", i), 64'(lat), 4);
      chk($sformatf("sum[%0d]", i), io32.sum, 64'(vt[i].sum));
      chk($sformatf("cout[%0d]", i), io32.cout, 64'(vt[i].cout));
      chk($sformatf("ovf[%0d]", i), io32.ovf, 64'(vt[i].ovf));
      drain32();
    end

    // backpressure: result held, new operands ignored
    start32(32'h000000FF, 32'h00000001, 0, 0);
    wait32(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      io32.in_valid = (i % 2 == 0);
      io32.a = $urandom; io32.b = $urandom;
      chk("bp_out_valid", io32.out_valid, 1);
      chk("bp_in_ready", io32.in_ready, 0);
      chk("bp_sum", io32.sum, 64'h100);
    end
    @(negedge clk);
    io32.in_valid = 1'b0;
    io32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io32.out_ready = 1'b0;
    chk("bp_idle_ready", io32.in_ready, 1);
    chk("bp_idle_sum", io32.sum, 64'h100);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_accept", io32.out_valid, 0);
    chk("bp_still_idle", io32.in_ready, 1);

    // async reset mid-RUN at k=2
    start32(32'h11111111, 32'h22222222, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_busy", io32.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", io32.out_valid, 0);
    chk("arst_sum", io32.sum, 0);
    chk("arst_in_ready", io32.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    start32(32'h0000FFFF, 32'h00000001, 0, 0);
    wait32(lat);
    chk("post_rst_lat", 64'(lat), 4);
    chk("post_rst_sum", io32.sum, 64'h00010000);
    chk("post_rst_cout", io32.cout, 0);
    drain32();

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            op3(a, b, c, s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
